tmds_decoder: RTL and testbench

Receive-side TMDS channel decoder for the HDMI path. It takes 10-bit parallel words from a per-channel deserializer at pixel clock, with arbitrary bit misalignment. It finds the symbol boundary by locking onto control-token runs in blanking, then decodes each aligned symbol into 8-bit pixel data, data-enable and the 2-bit control code (vh). One instance per channel; the blue instance's vh carries hsync/vsync.

---
 rtl/tmds_decoder.sv | 161 ++++++++++++++++
 tb/tb_tmds_decoder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS receive-channel decoder: word alignment by control-token run lock,
// then 10b -> 8b data decode plus control-code extraction.
// Optional feature macro: TMDS_DECODER_LOSS_CNT_EN enables the 8-bit
// saturating lock-loss counter on loss_cnt; otherwise loss_cnt is tied to 0.
module tmds_decoder #(
  parameter int CTRL_RUN  = 8,
  parameter int SLIP_WAIT = 2048,
  parameter int WATCHDOG  = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] raw,
  output logic [7:0] d,
  output logic       de,
  output logic [1:0] vh,
  output logic       locked,
  output logic [3:0] offset,
  output logic [7:0] loss_cnt
);

  localparam int CNT_MAX = (SLIP_WAIT > WATCHDOG) ? SLIP_WAIT : WATCHDOG;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int RUN_W   = $clog2(CTRL_RUN + 1);

  localparam logic [CNT_W-1:0] SLIP_LAST = CNT_W'(SLIP_WAIT - 1);
  localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(WATCHDOG - 1);
  localparam logic [RUN_W-1:0] RUN_FULL  = RUN_W'(CTRL_RUN);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(CTRL_RUN - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [9:0]       prev;
  logic [19:0]      cat;
  logic [9:0]       sym;
  logic [2:0]       tok;
  logic             is_tok;
  logic [1:0]       tok_code;
  logic [RUN_W-1:0] run;
  logic [CNT_W-1:0] cnt;
  logic             run_hit;
  logic             slip;
  logic             expire;

  // {is_token, code} for the four control tokens
  function automatic logic [2:0] tok_lookup(input logic [9:0] s);
    case (s)
      10'b1101010100: return 3'b100;
      10'b0010101011: return 3'b101;
      10'b0101010100: return 3'b110;
      10'b1010101011: return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

  // undo optional inversion, then undo the XOR/XNOR transition chain
  function automatic logic [7:0] tmds_data(input logic [9:0] s);
    logic [7:0] t;
    logic [7:0] o;
    t    = s[9] ? ~s[7:0] : s[7:0];
    o    = 8'd0;
    o[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      o[i] = s[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
    return o;
  endfunction

  function automatic logic [3:0] next_offset(input logic [3:0] o);
    return (o == 4'd9) ? 4'd0 : o + 4'd1;
  endfunction

  assign cat      = {raw, prev};
  assign sym      = 10'(cat >> offset);
  assign tok      = tok_lookup(sym);
  assign is_tok   = tok[2];
  assign tok_code = tok[1:0];

  // A qualifying run beats a simultaneous slip or watchdog expiry.
  assign run_hit = is_tok && (run >= RUN_LAST);
  assign slip    = (state == SEARCH) && (cnt == SLIP_LAST) && !run_hit;
  assign expire  = (state == LOCKED) && (cnt == WD_LAST) && !run_hit;
  assign locked  = (state == LOCKED);

  // previous raw word, low half of the 20-bit alignment window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 10'd0;
    else        prev <= raw;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEARCH;
    else        state <= state_nxt;
  end

  // FSM next-state: lock on a full token run, drop lock on watchdog expiry
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (run_hit) state_nxt = LOCKED;
      LOCKED:  if (expire)  state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  // token run, shared slip/watchdog counter and bit offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= '0;
      cnt    <= '0;
      offset <= 4'd0;
    end else begin
      if (slip || expire)      run <= '0;
      else if (!is_tok)        run <= '0;
      else if (run != RUN_FULL) run <= run + RUN_W'(1);

      if (run_hit || slip || expire) cnt <= '0;
      else                           cnt <= cnt + CNT_W'(1);

      if (slip || expire) offset <= next_offset(offset);
    end
  end

  // registered decode outputs; forced to idle values outside LOCKED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d  <= 8'd0;
      de <= 1'b0;
      vh <= 2'b00;
    end else if ((state == LOCKED) && !expire) begin
      if (is_tok) begin
        d  <= 8'd0;
        de <= 1'b0;
        vh <= tok_code;
      end else begin
        d  <= tmds_data(sym);
        de <= 1'b1;
      end
    end else begin
      d  <= 8'd0;
      de <= 1'b0;
      vh <= 2'b00;
    end
  end

`ifdef TMDS_DECODER_LOSS_CNT_EN
  logic [7:0] loss_q;

  // saturating count of LOCKED -> SEARCH transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         loss_q <= 8'd0;
    else if (expire && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock, decode table, slip search,
// watchdog loss, async reset and lock-loss counting.
module tb_tmds_decoder;

  localparam int CTRL_RUN  = 8;
  localparam int SLIP_WAIT = 64;
  localparam int WATCHDOG  = 128;
  localparam int NV        = 12;

`ifdef TMDS_DECODER_LOSS_CNT_EN
  localparam int NLOSS   = 300;
  localparam bit LOSS_EN = 1'b1;
`else
  localparam int NLOSS   = 3;
  localparam bit LOSS_EN = 1'b0;
`endif

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;

  typedef struct {
    logic [9:0] sym;
    logic [7:0] d;
    logic       de;
    logic [1:0] vh;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [9:0] raw;
  logic [7:0] d;
  logic       de;
  logic [1:0] vh;
  logic       locked;
  logic [3:0] offset;
  logic [7:0] loss_cnt;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         rot = 0;
  logic [9:0] last_sym = 10'd0;
  vec_t       tbl [NV];

  tmds_decoder #(
    .CTRL_RUN (CTRL_RUN),
    .SLIP_WAIT(SLIP_WAIT),
    .WATCHDOG (WATCHDOG)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw     (raw),
    .d       (d),
    .de      (de),
    .vh      (vh),
    .locked  (locked),
    .offset  (offset),
    .loss_cnt(loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, want completion");
    $fatal(1);
  end

  // transmitter-side encoder with the standard transition-minimising choice
  function automatic logic [9:0] enc(input logic [7:0] b, input logic inv);
    int         ones;
    logic       x;
    logic [7:0] q;
    ones = $countones(b);
    x    = (ones > 4) || (ones == 4 && !b[0]);
    q    = 8'd0;
    q[0] = b[0];
    for (int i = 1; i < 8; i++) q[i] = x ? ~(q[i-1] ^ b[i]) : (q[i-1] ^ b[i]);
    return {inv, ~x, inv ? ~q : q};
  endfunction

  function automatic logic [9:0] blank(input int j);
    return (((j / 4) % 2) != 0) ? T01 : T00;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [7:0] ed, input logic ede,
                         input logic [1:0] evh);
    chk({nm, ".d"}, 32'(d), 32'(ed));
    chk({nm, ".de"}, 32'(de), 32'(ede));
    chk({nm, ".vh"}, 32'(vh), 32'(evh));
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired, DUT event never seen", nm);
  endtask

  // send one symbol, bit-rotated by rot across the word boundary
  task automatic send(input logic [9:0] s);
    logic [19:0] c;
    c        = {s, last_sym};
    raw      = c[(10 - rot) +: 10];
    last_sym = s;
    @(posedge clk);
    #1;
  endtask

  // output after each send reflects the symbol sent one call earlier
  task automatic run_table(input string nm);
    for (int i = 0; i <= NV; i++) begin
      send((i < NV) ? tbl[i].sym : T00);
      if (i >= 1)
        chk_out($sformatf("%s[%0d]", nm, i - 1), tbl[i-1].d, tbl[i-1].de, tbl[i-1].vh);
    end
  endtask

  initial begin
    int         j;
    int         exp_off;
    logic [7:0] lm;
    bit         abort;

    tbl[0]  = '{T00,               8'h00, 1'b0, 2'b00};
    tbl[1]  = '{enc(8'hA5, 1'b0),  8'hA5, 1'b1, 2'b00};
    tbl[2]  = '{T11,               8'h00, 1'b0, 2'b11};
    tbl[3]  = '{enc(8'h3C, 1'b1),  8'h3C, 1'b1, 2'b11};
    tbl[4]  = '{enc(8'hFF, 1'b0),  8'hFF, 1'b1, 2'b11};
    tbl[5]  = '{enc(8'h00, 1'b1),  8'h00, 1'b1, 2'b11};
    tbl[6]  = '{T01,               8'h00, 1'b0, 2'b01};
    tbl[7]  = '{enc(8'h81, 1'b0),  8'h81, 1'b1, 2'b01};
    tbl[8]  = '{T10,               8'h00, 1'b0, 2'b10};
    tbl[9]  = '{enc(8'h5A, 1'b1),  8'h5A, 1'b1, 2'b10};
    tbl[10] = '{enc(8'h7E, 1'b0),  8'h7E, 1'b1, 2'b10};
    tbl[11] = '{T00,               8'h00, 1'b0, 2'b00};

    // reset state
    rst_n = 1'b0;
    raw   = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 8'h00, 1'b0, 2'b00);
    chk("reset.locked", 32'(locked), 32'd0);
    chk("reset.offset", 32'(offset), 32'd0);
    chk("reset.loss", 32'(loss_cnt), 32'd0);
    rst_n = 1'b1;

    // aligned lock at offset 0
    for (int k = 0; k < 10; k++) begin
      send(T00);
      if (k == 7) chk("lock_before_8th", 32'(locked), 32'd0);
      if (k == 8) chk("lock_after_8th", 32'(locked), 32'd1);
    end
    chk("lock.offset", 32'(offset), 32'd0);
    send(enc(8'hA5, 1'b0));
    chk_out("token_before_data", 8'h00, 1'b0, 2'b00);
    send(T00);
    chk_out("first_data", 8'hA5, 1'b1, 2'b00);

    run_table("aligned");

    // watchdog expiry on a data-only stream
    send(enc(8'h10, 1'b0));
    repeat (8) send(T00);
    for (int k = 1; k <= WATCHDOG + 1; k++) begin
      send(enc(8'h42, 1'b1));
      if (k == WATCHDOG) begin
        chk("wd_still_locked", 32'(locked), 32'd1);
        chk_out("wd_data", 8'h42, 1'b1, 2'b00);
      end
      if (k == WATCHDOG + 1) begin
        chk("wd_dropped", 32'(locked), 32'd0);
        chk("wd_offset", 32'(offset), 32'd1);
        chk("wd_loss", 32'(loss_cnt), LOSS_EN ? 32'd1 : 32'd0);
        chk_out("wd_outputs", 8'h00, 1'b0, 2'b00);
      end
    end
    for (int k = 0; k < 3; k++) begin
      send(enc(8'h42, 1'b1));
      chk_out($sformatf("search_idle[%0d]", k), 8'h00, 1'b0, 2'b00);
    end

    // rotated stream: search must step 0,1,2 and lock at 3
    rot      = 3;
    last_sym = T00;
    j        = 0;
    rst_n    = 1'b0;
    send(blank(j)); j++;
    chk("rst_offset", 32'(offset), 32'd0);
    send(blank(j)); j++;
    rst_n = 1'b1;
    for (int t = 1; t <= 3 * SLIP_WAIT + CTRL_RUN; t++) begin
      send(blank(j)); j++;
      if (t == SLIP_WAIT - 1) chk("slip_off0", 32'(offset), 32'd0);
      if (t == SLIP_WAIT) begin
        chk("slip_off1", 32'(offset), 32'd1);
        chk_out("slip_idle", 8'h00, 1'b0, 2'b00);
      end
      if (t == 2 * SLIP_WAIT) chk("slip_off2", 32'(offset), 32'd2);
      if (t == 3 * SLIP_WAIT) chk("slip_off3", 32'(offset), 32'd3);
      if (t == 3 * SLIP_WAIT + CTRL_RUN - 1) chk("rot_lock_early", 32'(locked), 32'd0);
      if (t == 3 * SLIP_WAIT + CTRL_RUN) chk("rot_lock", 32'(locked), 32'd1);
    end
    send(blank(j)); j++;
    send(blank(j)); j++;
    run_table("rotated");
    chk("rot_offset_kept", 32'(offset), 32'd3);

    // async reset while locked with live data
    send(T11);
    send(enc(8'hA5, 1'b0));
    send(enc(8'h3C, 1'b1));
    chk_out("pre_reset", 8'hA5, 1'b1, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_reset", 8'h00, 1'b0, 2'b00);
    chk("async_reset.locked", 32'(locked), 32'd0);
    chk("async_reset.offset", 32'(offset), 32'd0);
    chk("async_reset.loss", 32'(loss_cnt), 32'd0);
    rot = 0;
    send(T00);
    send(T00);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send(T00);
      if (k == 7) chk("relock_before_8th", 32'(locked), 32'd0);
      if (k == 8) chk("relock_after_8th", 32'(locked), 32'd1);
    end

    // repeated lock losses, relocking at each new offset
    exp_off = 0;
    lm      = 8'd0;
    abort   = 1'b0;
    for (int n = 1; n <= NLOSS && !abort; n++) begin
      int k;
      k = 0;
      do begin
        send(enc(8'h42, 1'b0));
        k++;
      end while (locked && k < 3 * WATCHDOG);
      if (locked) begin
        fail_now("loss_wait");
        abort = 1'b1;
      end else begin
        exp_off = (exp_off == 9) ? 0 : exp_off + 1;
        lm      = LOSS_EN ? ((lm == 8'hFF) ? 8'hFF : lm + 8'd1) : 8'd0;
        chk($sformatf("loss[%0d].offset", n), 32'(offset), 32'(exp_off));
        chk($sformatf("loss[%0d].cnt", n), 32'(loss_cnt), 32'(lm));
        chk($sformatf("loss[%0d].de", n), 32'(de), 32'd0);
        rot = exp_off;
        repeat (10) send(T00);
        chk($sformatf("loss[%0d].relock", n), 32'(locked), 32'd1);
      end
    end
`ifdef TMDS_DECODER_LOSS_CNT_EN
    chk("loss_saturated", 32'(loss_cnt), 32'd255);
`else
    chk("loss_tied_zero", 32'(loss_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
